// File: rtl/audio_i2s_pkg.sv
// rtl/audio_i2s_pkg.sv - shared widths, types and slot helpers for the I2S codec model
package audio_i2s_pkg;

    localparam int SAMPLE_W   = 24;
    localparam int SLOT_W     = 32;
    localparam int FRAME_BITS = 64;
    localparam int BIT_CNT_W  = $clog2(FRAME_BITS);
    localparam int SLOT_IDX_W = $clog2(SLOT_W);

    typedef logic [SAMPLE_W-1:0]   sample_t;
    typedef logic [BIT_CNT_W-1:0]  bit_cnt_t;
    typedef logic [SLOT_IDX_W-1:0] slot_t;

    // Serial bit carried in a slot, MSB first; slots outside the data window read as zero.
    function automatic logic slot_bit(input sample_t smp, input slot_t slot, input int delay);
        int idx;
        idx = SAMPLE_W - 1 + delay - int'(slot);
        if (idx >= 0 && idx < SAMPLE_W) begin
            return smp[idx[4:0]];
        end
        return 1'b0;
    endfunction

    function automatic logic is_data_slot(input slot_t slot, input int delay);
        return (int'(slot) >= delay) && (int'(slot) < SAMPLE_W + delay);
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// rtl/i2s_clkgen.sv - BCLK divider, frame bit counter and LR clock with rise/fall event strobes
module i2s_clkgen
    import audio_i2s_pkg::*;
#(
    parameter int BCLK_DIV = 8
) (
    input  logic     clk,
    input  logic     rst,
    output logic     bclk,
    output logic     lrck,
    output bit_cnt_t bit_cnt,
    output bit_cnt_t bit_cnt_next,
    output logic     rise_evt,
    output logic     fall_evt
);

    localparam int               DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             bclk_q, bclk_d;
    bit_cnt_t         bit_cnt_q, bit_cnt_d;
    logic             lrck_q, lrck_d;
    logic             wrap;

    // Events are flagged in the cycle whose closing edge moves bclk, so every
    // consequence of an edge lands in the same registers on that same edge.
    always_comb begin
        wrap      = (div_cnt_q == DIV_LAST);
        rise_evt  = wrap && !bclk_q;
        fall_evt  = wrap && bclk_q;
        div_cnt_d = wrap ? '0 : div_cnt_q + DIV_W'(1);
        bclk_d    = wrap ? ~bclk_q : bclk_q;
        bit_cnt_d = fall_evt ? bit_cnt_q + BIT_CNT_W'(1) : bit_cnt_q;
        lrck_d    = fall_evt ? bit_cnt_d[BIT_CNT_W-1] : lrck_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            bit_cnt_q <= '1;
            lrck_q    <= 1'b1;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
            bit_cnt_q <= bit_cnt_d;
            lrck_q    <= lrck_d;
        end
    end

    assign bclk         = bclk_q;
    assign lrck         = lrck_q;
    assign bit_cnt      = bit_cnt_q;
    assign bit_cnt_next = bit_cnt_d;

endmodule

// File: rtl/i2s_codec_model.sv
// rtl/i2s_codec_model.sv - I2S bus master standing in for the board audio CODEC digital port
module i2s_codec_model
    import audio_i2s_pkg::*;
#(
    parameter int BCLK_DIV   = 8,
    parameter int DATA_DELAY = 1
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [SAMPLE_W-1:0] adc_left_in,
    input  logic [SAMPLE_W-1:0] adc_right_in,
    output logic                frame_start,
    output logic [SAMPLE_W-1:0] dac_left_out,
    output logic [SAMPLE_W-1:0] dac_right_out,
    output logic                dac_valid,
    output logic                AUD_BCLK,
    output logic                AUD_ADCLRCK,
    output logic                AUD_DACLRCK,
    output logic                AUD_ADCDAT,
    input  logic                AUD_DACDAT
);

    localparam bit_cnt_t FRAME_LAST = bit_cnt_t'(FRAME_BITS - 1);
    localparam bit_cnt_t LEFT_LAST  = bit_cnt_t'(SAMPLE_W - 1 + DATA_DELAY);
    localparam bit_cnt_t RIGHT_LAST = bit_cnt_t'(SLOT_W + SAMPLE_W - 1 + DATA_DELAY);

    logic     bclk, lrck, rise_evt, fall_evt;
    bit_cnt_t bit_cnt, bit_cnt_next;

    i2s_clkgen #(
        .BCLK_DIV (BCLK_DIV)
    ) u_clkgen (
        .clk          (CLOCK_50),
        .rst          (reset),
        .bclk         (bclk),
        .lrck         (lrck),
        .bit_cnt      (bit_cnt),
        .bit_cnt_next (bit_cnt_next),
        .rise_evt     (rise_evt),
        .fall_evt     (fall_evt)
    );

    sample_t shadow_l_q, shadow_l_d;
    sample_t shadow_r_q, shadow_r_d;
    sample_t shift_l_q, shift_l_d;
    sample_t shift_r_q, shift_r_d;
    sample_t hold_l_q, hold_l_d;
    sample_t dac_left_q, dac_left_d;
    sample_t dac_right_q, dac_right_d;
    logic    adcdat_q, adcdat_d;
    logic    dac_valid_q, dac_valid_d;
    logic    frame_start_q, frame_start_d;
    logic    dacdat_s1_q, dacdat_s1_d;
    logic    dacdat_s2_q, dacdat_s2_d;

    logic    frame_evt;
    slot_t   cur_slot, next_slot;
    sample_t shift_l_next, shift_r_next;

    always_comb begin
        frame_evt    = fall_evt && (bit_cnt == FRAME_LAST);
        cur_slot     = bit_cnt[SLOT_IDX_W-1:0];
        next_slot    = bit_cnt_next[SLOT_IDX_W-1:0];
        shift_l_next = {shift_l_q[SAMPLE_W-2:0], dacdat_s2_q};
        shift_r_next = {shift_r_q[SAMPLE_W-2:0], dacdat_s2_q};

        shadow_l_d    = frame_evt ? adc_left_in : shadow_l_q;
        shadow_r_d    = frame_evt ? adc_right_in : shadow_r_q;
        frame_start_d = frame_evt;
        dacdat_s1_d   = AUD_DACDAT;
        dacdat_s2_d   = dacdat_s1_q;

        // Slot 0 of a new frame must already see the freshly latched shadow.
        adcdat_d = adcdat_q;
        if (fall_evt) begin
            adcdat_d = slot_bit(bit_cnt_next[BIT_CNT_W-1] ? shadow_r_d : shadow_l_d,
                                next_slot, DATA_DELAY);
        end

        shift_l_d   = shift_l_q;
        shift_r_d   = shift_r_q;
        hold_l_d    = hold_l_q;
        dac_left_d  = dac_left_q;
        dac_right_d = dac_right_q;
        dac_valid_d = 1'b0;
        if (rise_evt && is_data_slot(cur_slot, DATA_DELAY)) begin
            if (!bit_cnt[BIT_CNT_W-1]) begin
                shift_l_d = shift_l_next;
                if (bit_cnt == LEFT_LAST) begin
                    hold_l_d = shift_l_next;
                end
            end else begin
                shift_r_d = shift_r_next;
                if (bit_cnt == RIGHT_LAST) begin
                    dac_left_d  = hold_l_q;
                    dac_right_d = shift_r_next;
                    dac_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            shadow_l_q    <= '0;
            shadow_r_q    <= '0;
            shift_l_q     <= '0;
            shift_r_q     <= '0;
            hold_l_q      <= '0;
            dac_left_q    <= '0;
            dac_right_q   <= '0;
            adcdat_q      <= 1'b0;
            dac_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            dacdat_s1_q   <= 1'b0;
            dacdat_s2_q   <= 1'b0;
        end else begin
            shadow_l_q    <= shadow_l_d;
            shadow_r_q    <= shadow_r_d;
            shift_l_q     <= shift_l_d;
            shift_r_q     <= shift_r_d;
            hold_l_q      <= hold_l_d;
            dac_left_q    <= dac_left_d;
            dac_right_q   <= dac_right_d;
            adcdat_q      <= adcdat_d;
            dac_valid_q   <= dac_valid_d;
            frame_start_q <= frame_start_d;
            dacdat_s1_q   <= dacdat_s1_d;
            dacdat_s2_q   <= dacdat_s2_d;
        end
    end

    assign frame_start   = frame_start_q;
    assign dac_left_out  = dac_left_q;
    assign dac_right_out = dac_right_q;
    assign dac_valid     = dac_valid_q;
    assign AUD_BCLK      = bclk;
    assign AUD_ADCLRCK   = lrck;
    assign AUD_DACLRCK   = lrck;
    assign AUD_ADCDAT    = adcdat_q;

endmodule

// File: tb/tb_i2s_codec_model.sv
// tb/tb_i2s_codec_model.sv - scoreboard bench for the I2S codec model (I2S and left-justified loopback)
module tb_i2s_codec_model;

    localparam int DIV    = 8;
    localparam int FRAME  = 128 * DIV;
    localparam int DD_I2S = 1;
    localparam int DD_LJ  = 0;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [23:0] adc_l_i2s, adc_r_i2s, adc_l_lj, adc_r_lj;
    logic        fs_i2s, dv_i2s, bclk_i2s, alr_i2s, dlr_i2s, adat_i2s;
    logic        fs_lj, dv_lj, bclk_lj, alr_lj, dlr_lj, adat_lj;
    logic [23:0] dl_i2s, dr_i2s, dl_lj, dr_lj;

    i2s_codec_model #(.BCLK_DIV(DIV), .DATA_DELAY(DD_I2S)) dut_i2s (
        .CLOCK_50      (clk),
        .reset         (reset),
        .adc_left_in   (adc_l_i2s),
        .adc_right_in  (adc_r_i2s),
        .frame_start   (fs_i2s),
        .dac_left_out  (dl_i2s),
        .dac_right_out (dr_i2s),
        .dac_valid     (dv_i2s),
        .AUD_BCLK      (bclk_i2s),
        .AUD_ADCLRCK   (alr_i2s),
        .AUD_DACLRCK   (dlr_i2s),
        .AUD_ADCDAT    (adat_i2s),
        .AUD_DACDAT    (adat_i2s)
    );

    i2s_codec_model #(.BCLK_DIV(DIV), .DATA_DELAY(DD_LJ)) dut_lj (
        .CLOCK_50      (clk),
        .reset         (reset),
        .adc_left_in   (adc_l_lj),
        .adc_right_in  (adc_r_lj),
        .frame_start   (fs_lj),
        .dac_left_out  (dl_lj),
        .dac_right_out (dr_lj),
        .dac_valid     (dv_lj),
        .AUD_BCLK      (bclk_lj),
        .AUD_ADCLRCK   (alr_lj),
        .AUD_DACLRCK   (dlr_lj),
        .AUD_ADCDAT    (adat_lj),
        .AUD_DACDAT    (adat_lj)
    );

    int n_checks = 0;
    int n_passed = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got === exp) n_passed++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    endtask

    always @(posedge clk) begin
        if (reset) cyc = 0;
        else       cyc = cyc + 1;
    end

    // Scoreboard: one queue per consumer per instance, entries are {left, right}.
    logic [47:0] sq_adc_0[$], sq_dac_0[$], sq_adc_1[$], sq_dac_1[$];

    function automatic void sb_push(input int i, input logic [47:0] v);
        if (i == 0) begin sq_adc_0.push_back(v); sq_dac_0.push_back(v); end
        else        begin sq_adc_1.push_back(v); sq_dac_1.push_back(v); end
    endfunction

    function automatic logic [48:0] sb_pop(input int i, input logic dac);
        logic [48:0] r;
        r = {1'b1, 48'h0};
        if (i == 0 && dac && sq_dac_0.size() > 0)       r = {1'b0, sq_dac_0.pop_front()};
        else if (i == 0 && !dac && sq_adc_0.size() > 0) r = {1'b0, sq_adc_0.pop_front()};
        else if (i == 1 && dac && sq_dac_1.size() > 0)  r = {1'b0, sq_dac_1.pop_front()};
        else if (i == 1 && !dac && sq_adc_1.size() > 0) r = {1'b0, sq_adc_1.pop_front()};
        return r;
    endfunction

    function automatic logic [31:0] slot_word(input logic [23:0] s, input int dd);
        return (dd == 1) ? {1'b0, s, 7'b0} : {s, 8'b0};
    endfunction

    logic        prev_b [2], prev_lr [2], left_ok [2];
    int          rise_idx [2];
    logic [31:0] sw [2], left_word [2];
    int          fs_bad [2], dv_bad [2], lr_bad [2], n_dv [2];
    int          t_rise1 [2], t_rise2 [2], t_bfall1 [2], t_lrf1 [2], t_lrr1 [2], t_lrf2 [2];

    always @(negedge clk) begin
        logic        b [2], lr [2], ad [2], fsv [2], dvv [2], dlrv [2];
        logic [23:0] dlv [2], drv [2], al [2], ar [2];
        logic [48:0] e;
        int          dd, dv_at;
        logic        exp_fs, exp_dv;
        b[0] = bclk_i2s; lr[0] = alr_i2s; ad[0] = adat_i2s; fsv[0] = fs_i2s; dvv[0] = dv_i2s;
        b[1] = bclk_lj;  lr[1] = alr_lj;  ad[1] = adat_lj;  fsv[1] = fs_lj;  dvv[1] = dv_lj;
        dlrv[0] = dlr_i2s; dlrv[1] = dlr_lj;
        dlv[0] = dl_i2s; drv[0] = dr_i2s; dlv[1] = dl_lj; drv[1] = dr_lj;
        al[0] = adc_l_i2s; ar[0] = adc_r_i2s; al[1] = adc_l_lj; ar[1] = adc_r_lj;
        if (reset) begin
            sq_adc_0.delete(); sq_dac_0.delete(); sq_adc_1.delete(); sq_dac_1.delete();
        end
        for (int i = 0; i < 2; i++) begin
            dd = (i == 0) ? DD_I2S : DD_LJ;
            if (reset) begin
                prev_b[i] = b[i]; prev_lr[i] = lr[i]; left_ok[i] = 1'b0;
                rise_idx[i] = 0; sw[i] = '0;
                t_rise1[i] = -1; t_rise2[i] = -1; t_bfall1[i] = -1;
                t_lrf1[i] = -1; t_lrr1[i] = -1; t_lrf2[i] = -1;
            end else begin
                if (dlrv[i] !== lr[i]) lr_bad[i]++;
                exp_fs = (cyc >= 2 * DIV) && ((cyc - 2 * DIV) % FRAME == 0);
                if (fsv[i] !== exp_fs) fs_bad[i]++;
                if (exp_fs) sb_push(i, {al[i], ar[i]});
                dv_at  = 2 * DIV * (56 + dd) + DIV;
                exp_dv = (cyc >= dv_at) && ((cyc - dv_at) % FRAME == 0);
                if (dvv[i] !== exp_dv) dv_bad[i]++;
                if (dvv[i]) begin
                    n_dv[i]++;
                    e = sb_pop(i, 1'b1);
                    check_eq($sformatf("sb_dac_empty%0d", i), {47'h0, e[48]}, 48'h0);
                    if (!e[48]) begin
                        check_eq($sformatf("dac_left%0d", i), {24'h0, dlv[i]}, {24'h0, e[47:24]});
                        check_eq($sformatf("dac_right%0d", i), {24'h0, drv[i]}, {24'h0, e[23:0]});
                    end
                end
                if (b[i] && !prev_b[i]) begin
                    if (t_rise1[i] < 0) t_rise1[i] = cyc;
                    else if (t_rise2[i] < 0) t_rise2[i] = cyc;
                    sw[i] = {sw[i][30:0], ad[i]};
                    rise_idx[i]++;
                end
                if (!b[i] && prev_b[i] && t_bfall1[i] < 0) t_bfall1[i] = cyc;
                if (lr[i] !== prev_lr[i]) begin
                    if (!lr[i]) begin
                        if (t_lrf1[i] < 0) t_lrf1[i] = cyc;
                        else if (t_lrf2[i] < 0) t_lrf2[i] = cyc;
                    end else if (t_lrr1[i] < 0) begin
                        t_lrr1[i] = cyc;
                    end
                    if (rise_idx[i] == 32) begin
                        if (!prev_lr[i]) begin
                            left_word[i] = sw[i];
                            left_ok[i]   = 1'b1;
                        end else if (left_ok[i]) begin
                            e = sb_pop(i, 1'b0);
                            check_eq($sformatf("sb_adc_empty%0d", i), {47'h0, e[48]}, 48'h0);
                            if (!e[48]) begin
                                check_eq($sformatf("adc_left_slots%0d", i), {16'h0, left_word[i]},
                                         {16'h0, slot_word(e[47:24], dd)});
                                check_eq($sformatf("adc_right_slots%0d", i), {16'h0, sw[i]},
                                         {16'h0, slot_word(e[23:0], dd)});
                            end
                        end
                    end
                    rise_idx[i] = 0;
                    sw[i]       = '0;
                end
                prev_b[i]  = b[i];
                prev_lr[i] = lr[i];
            end
        end
    end

    task automatic run_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_timing(input string sfx);
        check_eq({"bclk_first_rise", sfx}, 48'(t_rise1[0]), 48'(DIV));
        check_eq({"bclk_second_rise", sfx}, 48'(t_rise2[0]), 48'(3 * DIV));
        check_eq({"bclk_first_fall", sfx}, 48'(t_bfall1[0]), 48'(2 * DIV));
        check_eq({"lrck_first_fall", sfx}, 48'(t_lrf1[0]), 48'(2 * DIV));
        check_eq({"lrck_first_rise", sfx}, 48'(t_lrr1[0]), 48'(2 * DIV + FRAME / 2));
        check_eq({"lrck_second_fall", sfx}, 48'(t_lrf2[0]), 48'(2 * DIV + FRAME));
    endtask

    initial begin
        adc_l_i2s = 24'hA50FC3; adc_r_i2s = 24'h800001;
        adc_l_lj  = 24'h800000; adc_r_lj  = 24'h00F00F;
        for (int i = 0; i < 2; i++) begin
            fs_bad[i] = 0; dv_bad[i] = 0; lr_bad[i] = 0; n_dv[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_bclk", {47'h0, bclk_i2s}, 48'h0);
        check_eq("rst_adclrck", {47'h0, alr_i2s}, 48'h1);
        check_eq("rst_daclrck", {47'h0, dlr_i2s}, 48'h1);
        check_eq("rst_adcdat", {47'h0, adat_i2s}, 48'h0);
        check_eq("rst_dac_out", {dl_i2s, dr_i2s}, 48'h0);
        check_eq("rst_pulses", {46'h0, dv_i2s, fs_i2s}, 48'h0);

        @(posedge clk);
        #1 reset = 1'b0;
        run_to(300);
        adc_l_i2s = 24'h123456;
        run_to(930);
        check_eq("loop_left_frame0", {24'h0, dl_i2s}, 48'hA50FC3);
        check_eq("loop_right_frame0", {24'h0, dr_i2s}, 48'h800001);
        check_eq("lj_left_frame0", {24'h0, dl_lj}, 48'h800000);
        run_to(1100);
        check_timing("");
        run_to(1950);
        check_eq("loop_left_frame1", {24'h0, dl_i2s}, 48'h123456);

        // Mid right half, BCLK high and ADCDAT carrying the right MSB.
        run_to(3625);
        check_eq("pre_rst_bclk", {47'h0, bclk_i2s}, 48'h1);
        check_eq("pre_rst_adcdat", {47'h0, adat_i2s}, 48'h1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_bclk", {47'h0, bclk_i2s}, 48'h0);
        check_eq("mid_rst_lrck", {47'h0, alr_i2s}, 48'h1);
        check_eq("mid_rst_adcdat", {47'h0, adat_i2s}, 48'h0);
        check_eq("mid_rst_dac_out", {dl_i2s, dr_i2s}, 48'h0);
        check_eq("mid_rst_lj_dac_out", {dl_lj, dr_lj}, 48'h0);
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        run_to(2100);
        check_timing("_after_rst");
        check_eq("loop_left_after_rst", {24'h0, dl_i2s}, 48'h123456);

        for (int i = 0; i < 2; i++) begin
            check_eq($sformatf("frame_start_position%0d", i), 48'(fs_bad[i]), 48'h0);
            check_eq($sformatf("dac_valid_position%0d", i), 48'(dv_bad[i]), 48'h0);
            check_eq($sformatf("daclrck_follows%0d", i), 48'(lr_bad[i]), 48'h0);
            check_eq($sformatf("dac_valid_count%0d", i), 48'(n_dv[i]), 48'd5);
        end
        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
